// File: rtl/alu_execute.sv
// R-format execute stage: single-cycle logic/arith ops plus an iterative
// shift-add multiplier, with a one-entry output holding register toward writeback.
module alu_execute #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             reset_input,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_operation,
    input  logic [4:0]       rd_address_in,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [4:0]       rd_address_out,
    output logic             write_enabled,
    output logic             illegal_op,
    input  logic             out_ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES);

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [4:0]       rd_q,        rd_d;
    logic             illegal_q,   illegal_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q,  in_ready_d;
    logic             we_q,        we_d;
    logic [WIDTH-1:0] mcand_q,     mcand_d;
    logic [WIDTH-1:0] mplier_q,    mplier_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic [WIDTH-1:0] alu_result_s;
    logic             alu_illegal_s;

    // Single-cycle operation decode straight from the input operands.
    always_comb begin
        alu_result_s  = {WIDTH{1'b0}};
        alu_illegal_s = 1'b0;
        case (ALU_operation)
            OP_AND:  alu_result_s = rs_data & rt_data;
            OP_OR:   alu_result_s = rs_data | rt_data;
            OP_ADD:  alu_result_s = rs_data + rt_data;
            OP_XOR:  alu_result_s = rs_data ^ rt_data;
            OP_NOR:  alu_result_s = ~(rs_data | rt_data);
            OP_SLTU: alu_result_s = {{(WIDTH-1){1'b0}}, (rs_data < rt_data)};
            OP_SUB:  alu_result_s = rs_data - rt_data;
            OP_SLT:  alu_result_s = {{(WIDTH-1){1'b0}}, ($signed(rs_data) < $signed(rt_data))};
            OP_MUL:  alu_result_s = {WIDTH{1'b0}};
            default: alu_illegal_s = 1'b1;
        endcase
    end

    // Next-state logic for the control FSM, multiplier and result register.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        rd_d       = rd_q;
        illegal_d  = illegal_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rd_d = rd_address_in;
                    if (ALU_operation == OP_MUL) begin
                        state_d    = ST_MUL;
                        mcand_d    = rs_data;
                        mplier_d   = rt_data;
                        acc_d      = {WIDTH{1'b0}};
                        cnt_d      = {CNT_W{1'b0}};
                        out_data_d = {WIDTH{1'b0}};
                        illegal_d  = 1'b0;
                    end else begin
                        state_d    = ST_HOLD;
                        out_data_d = alu_result_s;
                        illegal_d  = alu_illegal_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                // Steps run while cnt < MUL_CYCLES; the extra cycle transfers the product.
                if (cnt_q != MUL_LAST) begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end else begin
                        acc_d = acc_q;
                    end
                    mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                    cnt_d    = cnt_q + CNT_W'(1);
                end else begin
                    state_d    = ST_HOLD;
                    out_data_d = acc_q;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        out_valid_d = (state_d == ST_HOLD);
        in_ready_d  = (state_d == ST_IDLE);
        we_d        = (state_d == ST_HOLD) && !illegal_d && (rd_d != 5'd0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_input) begin
            state_q     <= ST_IDLE;
            out_data_q  <= {WIDTH{1'b0}};
            rd_q        <= 5'd0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            we_q        <= 1'b0;
            mcand_q     <= {WIDTH{1'b0}};
            mplier_q    <= {WIDTH{1'b0}};
            acc_q       <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            rd_q        <= rd_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            we_q        <= we_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign rd_address_out = rd_q;
    assign write_enabled  = we_q;
    assign illegal_op     = illegal_q;

endmodule

// File: tb/tb_alu_execute.sv
// Directed self-checking bench for alu_execute: one task per scenario.
module tb_alu_execute;

    logic        clk = 1'b0;
    logic        reset_input;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALU_operation;
    logic [4:0]  rd_address_in;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  rd_address_out;
    logic        write_enabled;
    logic        illegal_op;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    alu_execute #(.WIDTH(32), .MUL_CYCLES(32)) dut (
        .clk            (clk),
        .reset_input    (reset_input),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ALU_operation  (ALU_operation),
        .rd_address_in  (rd_address_in),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .rd_address_out (rd_address_out),
        .write_enabled  (write_enabled),
        .illegal_op     (illegal_op),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation and returns just after the handshake edge.
    task automatic issue(input logic [3:0] op, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b);
        ALU_operation = op;
        rd_address_in = rd;
        rs_data       = a;
        rt_data       = b;
        in_valid      = 1'b1;
        step();
        in_valid      = 1'b0;
    endtask

    task automatic test_reset();
        reset_input = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        ALU_operation = 4'd0; rd_address_in = 5'd0; rs_data = 32'd0; rt_data = 32'd0;
        step(); step();
        checks++;
        if (out_valid !== 1'b0 || write_enabled !== 1'b0 || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got v=%b we=%b ill=%b want 0 0 0", out_valid, write_enabled, illegal_op);
        end
        checks++;
        if (out_data !== 32'd0 || rd_address_out !== 5'd0) begin
            errors++;
            $display("FAIL reset_data got data=%h rd=%0d want 0 0", out_data, rd_address_out);
        end
        reset_input = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        issue(4'd2, 5'd13, 32'h0000_0005, 32'h0000_0003);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_0008 || rd_address_out !== 5'd13 ||
            write_enabled !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL add got v=%b data=%h rd=%0d we=%b rdy=%b want 1 00000008 13 1 0",
                     out_valid, out_data, rd_address_out, write_enabled, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_consume got v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_ops();
        logic [3:0]  ops  [8] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd6, 4'd7, 4'd5, 4'd2};
        logic [31:0] as   [8] = '{32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234,
                                  32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs   [8] = '{32'h0FF0_00FF, 32'h0FF0_00FF, 32'h0FF0_00FF, 32'h0FF0_00FF,
                                  32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002};
        logic [31:0] exps [8] = '{32'h00F0_0034, 32'hFFF0_12FF, 32'hFF00_12CB, 32'h000F_ED00,
                                  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], 5'd3, as[i], bs[i]);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exps[i] || illegal_op !== 1'b0) begin
                errors++;
                $display("FAIL op%0d got v=%b data=%h ill=%b want 1 %h 0",
                         ops[i], out_valid, out_data, illegal_op, exps[i]);
            end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int cyc = 0;
        bit rdy_bad = 1'b0;
        issue(4'd8, 5'd9, a, b);
        // Offer a competing op and out_ready during MUL; both must be ignored.
        ALU_operation = 4'd2; in_valid = 1'b1; out_ready = 1'b1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            if (in_ready !== 1'b0) rdy_bad = 1'b1;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (cyc != 33 || rdy_bad) begin
            errors++;
            $display("FAIL mul_latency got %0d cycles rdy_bad=%b want 33 0", cyc, rdy_bad);
        end
        checks++;
        if (out_data !== exp || rd_address_out !== 5'd9 || write_enabled !== 1'b1) begin
            errors++;
            $display("FAIL mul_data got data=%h rd=%0d we=%b want %h 9 1",
                     out_data, rd_address_out, write_enabled, exp);
        end
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_consume got v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        bit bad = 1'b0;
        out_ready = 1'b0;
        issue(4'd2, 5'd5, 32'h0000_0010, 32'h0000_0020);
        ALU_operation = 4'd3; rs_data = 32'hDEAD_BEEF; rd_address_in = 5'd7; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_data !== 32'h0000_0030 || rd_address_out !== 5'd5 ||
                in_ready !== 1'b0) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL backpressure_hold got v=%b data=%h rd=%0d rdy=%b want 1 00000030 5 0",
                     out_valid, out_data, rd_address_out, in_ready);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release got v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        issue(4'd12, 5'd7, 32'h1234_5678, 32'h1111_1111);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd0 || illegal_op !== 1'b1 || write_enabled !== 1'b0) begin
            errors++;
            $display("FAIL illegal got v=%b data=%h ill=%b we=%b want 1 00000000 1 0",
                     out_valid, out_data, illegal_op, write_enabled);
        end
        step();
        issue(4'd0, 5'd0, 32'hFFFF_0000, 32'h0F0F_0F0F);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0F0F_0000 || illegal_op !== 1'b0 || write_enabled !== 1'b0) begin
            errors++;
            $display("FAIL rd_zero got v=%b data=%h ill=%b we=%b want 1 0f0f0000 0 0",
                     out_valid, out_data, illegal_op, write_enabled);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit bad = 1'b0;
        out_ready = 1'b1;
        issue(4'd2, 5'd1, 32'd100, 32'd23);
        ALU_operation = 4'd6; rd_address_in = 5'd2; rs_data = 32'd50; rt_data = 32'd8; in_valid = 1'b1;
        if (out_valid !== 1'b1 || out_data !== 32'd123 || in_ready !== 1'b0) bad = 1'b1;
        step();
        if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        step();
        in_valid = 1'b0;
        if (out_valid !== 1'b1 || out_data !== 32'd42 || rd_address_out !== 5'd2) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL back_to_back got v=%b data=%0d rd=%0d want 1 42 2", out_valid, out_data, rd_address_out);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        bit seen = 1'b0;
        out_ready = 1'b0;
        issue(4'd8, 5'd4, 32'h0000_0003, 32'h0000_0005);
        for (int i = 0; i < 9; i++) step();
        reset_input = 1'b1;
        step();
        reset_input = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_mul got v=%b rdy=%b data=%h want 0 1 0", out_valid, in_ready, out_data);
        end
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            step();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_result got out_valid=1 want 0");
        end
        // Reset wins over a handshake at the same edge.
        ALU_operation = 4'd2; rd_address_in = 5'd6; rs_data = 32'd1; rt_data = 32'd1;
        in_valid = 1'b1; reset_input = 1'b1;
        step();
        in_valid = 1'b0; reset_input = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_priority got v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ops();
        test_mul(32'h0001_0001, 32'h0001_0001, 32'h0002_0001);
        test_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
